// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one data-cache request/response port between NUM_REQ requesters.
// Tracks the single in-flight access and steers the cache response back to its owner.
//
// state | meaning
// FREE  | no access in flight; responses arriving now are orphans
// BUSY  | one access in flight, owned by owner_r
module dcache_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_LENGTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             s_req_valid,
  input  logic [NUM_REQ*ADDR_LENGTH-1:0] s_req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   s_req_wdata,
  input  logic [NUM_REQ-1:0]             s_req_write,
  input  logic [NUM_REQ*3-1:0]           s_req_size,
  output logic [NUM_REQ-1:0]             s_req_ready,
  output logic [NUM_REQ-1:0]             s_resp_valid,
  output logic [WORD_SIZE-1:0]           s_resp_rdata,
  output logic                           m_req_valid,
  output logic [ADDR_LENGTH-1:0]         m_req_addr,
  output logic [WORD_SIZE-1:0]           m_req_wdata,
  output logic                           m_req_write,
  output logic [2:0]                     m_req_size,
  input  logic                           m_req_ready,
  input  logic                           m_resp_valid,
  input  logic [WORD_SIZE-1:0]           m_resp_rdata,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           resp_orphan
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_r, state_nxt;
  logic [IDX_W-1:0] last_grant_r, owner_r, sel;
  logic             any_valid, accept, complete;

  // First valid index strictly after the last grant, wrapping.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_valid && s_req_valid[(int'(last_grant_r) + k) % NUM_REQ]) begin
        any_valid = 1'b1;
        sel       = IDX_W'((int'(last_grant_r) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    m_req_addr  = '0;
    m_req_wdata = '0;
    m_req_write = 1'b0;
    m_req_size  = '0;
    s_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (any_valid && sel == IDX_W'(i)) begin
        m_req_addr     = s_req_addr[i*ADDR_LENGTH +: ADDR_LENGTH];
        m_req_wdata    = s_req_wdata[i*WORD_SIZE +: WORD_SIZE];
        m_req_write    = s_req_write[i];
        m_req_size     = s_req_size[i*3 +: 3];
        s_req_ready[i] = m_req_ready;
      end
    end
  end

  assign m_req_valid  = any_valid;
  assign accept       = m_req_valid && m_req_ready;
  // A write miss completes when the cache goes ready again without a response.
  assign complete     = (state_r == BUSY) && (m_resp_valid || m_req_ready);
  assign s_resp_rdata = m_resp_rdata;
  assign owner        = owner_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FREE;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      owner_r      <= '0;
    end else begin
      state_r <= state_nxt;
      if (accept) begin
        last_grant_r <= sel;
        owner_r      <= sel;
      end
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      FREE:    if (accept) state_nxt = BUSY;
      BUSY:    if (complete && !accept) state_nxt = FREE;
      default: state_nxt = FREE;
    endcase
  end

  // Response goes to the owner registered before this edge, even if a new accept lands now.
  always_comb begin
    busy         = (state_r == BUSY);
    s_resp_valid = '0;
    resp_orphan  = 1'b0;
    if (m_resp_valid) begin
      if (state_r == BUSY) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_r == IDX_W'(i)) s_resp_valid[i] = 1'b1;
        end
      end else begin
        resp_orphan = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Bench for dcache_req_arbiter (three requesters): directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the arbitration and ownership rules.
module tb_dcache_req_arbiter;
  localparam int N = 3;
  localparam int A = 32;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_req_valid, s_req_write, s_req_ready, s_resp_valid;
  logic [N*A-1:0] s_req_addr;
  logic [N*W-1:0] s_req_wdata;
  logic [N*3-1:0] s_req_size;
  logic [W-1:0]   s_resp_rdata, m_req_wdata, m_resp_rdata;
  logic [A-1:0]   m_req_addr;
  logic           m_req_valid, m_req_write, m_req_ready, m_resp_valid;
  logic [2:0]     m_req_size;
  logic           busy, resp_orphan;
  logic [1:0]     owner;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_last, m_owner;
  bit m_busy;

  logic [N-1:0] o_ready, o_resp, e_acc;
  logic [A-1:0] o_addr;
  logic [W-1:0] o_rdata;
  logic         o_busy, o_orphan;
  logic [1:0]   o_owner;

  dcache_req_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .ADDR_LENGTH(A)) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_req_write(s_req_write), .s_req_size(s_req_size), .s_req_ready(s_req_ready),
    .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata),
    .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_req_write(m_req_write), .m_req_size(m_req_size), .m_req_ready(m_req_ready),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .busy(busy), .owner(owner), .resp_orphan(resp_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = N - 1;
    m_owner = 0;
    m_busy  = 1'b0;
  endtask

  function automatic int exp_sel();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (s_req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int p, input bit v, input logic [A-1:0] a,
                         input logic [W-1:0] d, input bit w, input logic [2:0] sz);
    s_req_valid[p]      = v;
    s_req_addr[p*A +: A] = a;
    s_req_wdata[p*W +: W] = d;
    s_req_write[p]      = w;
    s_req_size[p*3 +: 3] = sz;
  endtask

  // Called at a negedge with inputs applied; checks, advances one clock, returns at next negedge.
  task automatic step();
    int s;
    logic [N-1:0] e_rdy, e_resp;
    logic [A-1:0] e_addr;
    logic [W-1:0] e_wdata;
    logic         e_write;
    logic [2:0]   e_size;
    #1;
    if (rst) model_reset();
    s = exp_sel();
    e_rdy = '0; e_resp = '0; e_addr = '0; e_wdata = '0; e_write = 1'b0; e_size = '0;
    if (s >= 0) begin
      if (m_req_ready) e_rdy[s] = 1'b1;
      e_addr  = s_req_addr[s*A +: A];
      e_wdata = s_req_wdata[s*W +: W];
      e_write = s_req_write[s];
      e_size  = s_req_size[s*3 +: 3];
    end
    if (m_resp_valid && m_busy) e_resp[m_owner] = 1'b1;
    chk("m_req_valid", 64'(m_req_valid), 64'(s >= 0));
    chk("m_req_addr", 64'(m_req_addr), 64'(e_addr));
    chk("m_req_wdata", 64'(m_req_wdata), 64'(e_wdata));
    chk("m_req_write", 64'(m_req_write), 64'(e_write));
    chk("m_req_size", 64'(m_req_size), 64'(e_size));
    chk("s_req_ready", 64'(s_req_ready), 64'(e_rdy));
    chk("s_resp_valid", 64'(s_resp_valid), 64'(e_resp));
    chk("s_resp_rdata", 64'(s_resp_rdata), 64'(m_resp_rdata));
    chk("resp_orphan", 64'(resp_orphan), 64'(m_resp_valid && !m_busy));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("owner", 64'(owner), 64'(m_owner));
    o_ready = s_req_ready; o_resp = s_resp_valid; o_addr = m_req_addr; o_rdata = s_resp_rdata;
    o_busy = busy; o_orphan = resp_orphan; o_owner = owner; e_acc = e_rdy;
    @(posedge clk);
    if (rst) model_reset();
    else if (s >= 0 && m_req_ready) begin
      m_last = s; m_owner = s; m_busy = 1'b1;
    end else if (m_busy && (m_resp_valid || m_req_ready)) m_busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    s_req_valid = '0; s_req_write = '0; s_req_addr = '0; s_req_wdata = '0; s_req_size = '0;
    m_req_ready = 1'b1; m_resp_valid = 1'b0; m_resp_rdata = 32'h1234_5678;
    model_reset();
    e_acc = '0;
    @(negedge clk);
    step();
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_owner", 64'(o_owner), 64'd0);
    rst = 1'b0;

    // fairness: ports 0 and 1 always valid, cache answers one cycle after each accept
    set_req(0, 1, 32'h0000_1000, 32'hA0A0_A0A0, 0, 3'd2);
    set_req(1, 1, 32'h0000_2000, 32'hB1B1_B1B1, 0, 3'd2);
    m_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      m_resp_valid = (c > 0);
      m_resp_rdata = 32'h100 + 32'(c);
      step();
      chk("fair_grant", 64'(o_ready), (c % 2 == 0) ? 64'b001 : 64'b010);
      if (c > 0) chk("fair_resp", 64'(o_resp), (c % 2 == 1) ? 64'b001 : 64'b010);
    end
    s_req_valid = '0; m_resp_valid = 1'b1;
    step();
    chk("fair_resp_last", 64'(o_resp), 64'b010);

    // overlap: response to port 1 while port 0 is accepted
    m_resp_valid = 1'b0;
    set_req(1, 1, 32'h0000_0040, 32'h0, 0, 3'd2);
    step();
    chk("ovl_grant1", 64'(o_ready), 64'b010);
    set_req(1, 0, 32'h0, 32'h0, 0, 3'd0);
    set_req(0, 1, 32'h0000_0080, 32'h5555_AAAA, 1, 3'd2);
    m_resp_valid = 1'b1; m_resp_rdata = 32'hDEAD_BEEF;
    step();
    chk("ovl_resp", 64'(o_resp), 64'b010);
    chk("ovl_rdata", 64'(o_rdata), 64'hDEAD_BEEF);
    chk("ovl_grant0", 64'(o_ready), 64'b001);
    s_req_valid = '0; m_resp_valid = 1'b0; m_req_ready = 1'b0;
    step();
    chk("ovl_owner", 64'(o_owner), 64'd0);
    chk("ovl_busy", 64'(o_busy), 64'd1);
    m_req_ready = 1'b1; m_resp_valid = 1'b1;
    step();
    m_resp_valid = 1'b0;

    // write miss: completes silently when the cache is ready again
    set_req(0, 1, 32'h0000_0100, 32'hCAFE_F00D, 1, 3'd2);
    step();
    chk("wm_grant", 64'(o_ready), 64'b001);
    s_req_valid = '0; m_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("wm_busy", 64'(o_busy), 64'd1);
      chk("wm_noresp", 64'(o_resp), 64'd0);
    end
    m_req_ready = 1'b1;
    step();
    chk("wm_noresp_done", 64'(o_resp), 64'd0);
    m_req_ready = 1'b0;
    step();
    chk("wm_idle", 64'(o_busy), 64'd0);

    // stall: selection must hold while the cache is not ready
    set_req(0, 1, 32'h0000_0A00, 32'h1, 0, 3'd0);
    set_req(1, 1, 32'h0000_0B00, 32'h2, 0, 3'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_addr", 64'(o_addr), 64'h0000_0B00);
      chk("stall_ready", 64'(o_ready), 64'd0);
    end
    m_req_ready = 1'b1;
    step();
    chk("stall_grant", 64'(o_ready), 64'b010);
    set_req(1, 0, 32'h0, 32'h0, 0, 3'd0);
    m_resp_valid = 1'b1;
    step();
    chk("stall_grant0", 64'(o_ready), 64'b001);
    s_req_valid = '0;
    step();
    m_resp_valid = 1'b0;

    // three requesters: pointer wraps past the top index
    set_req(2, 1, 32'h0000_0C00, 32'h3, 0, 3'd2);
    step();
    chk("wrap_g2", 64'(o_ready), 64'b100);
    set_req(0, 1, 32'h0000_0D00, 32'h4, 0, 3'd2);
    step();
    chk("wrap_g0", 64'(o_ready), 64'b001);
    step();
    chk("wrap_g2b", 64'(o_ready), 64'b100);
    s_req_valid = '0;
    step();

    // reset during an access discards ownership; a late response is an orphan
    set_req(1, 1, 32'h0000_0E00, 32'h5, 0, 3'd2);
    step();
    s_req_valid = '0; m_req_ready = 1'b0;
    step();
    chk("pre_rst_busy", 64'(o_busy), 64'd1);
    rst = 1'b1; m_resp_valid = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_resp", 64'(s_resp_valid), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("orphan", 64'(o_orphan), 64'd1);
    chk("orphan_resp", 64'(o_resp), 64'd0);
    m_resp_valid = 1'b0;

    // randomized traffic; an unaccepted requester holds its request
    for (int t = 0; t < 400; t++) begin
      for (int p = 0; p < N; p++) begin
        if (!(s_req_valid[p] && !e_acc[p]))
          set_req(p, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)));
      end
      m_req_ready  = ($urandom_range(0, 2) != 0);
      m_resp_valid = ($urandom_range(0, 3) == 0);
      m_resp_rdata = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
